core_inst_seq: RTL and testbench

//  Instruction sequencer directly upstream of core: generates the 34-bit inst word per cycle for the

---
 rtl/core_inst_seq_pkg.sv | 44 ++++
 rtl/core_inst_seq_pack.sv | 41 ++++
 rtl/core_inst_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_core_inst_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_inst_seq_pkg.sv
// Shared definitions for the core instruction sequencer: instruction field
// positions, sequencer state encoding and the idle instruction word.
package core_inst_seq_pkg;

  localparam int unsigned INST_W = 34;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned KIJ_W  = 4;

  // Instruction word bit positions
  localparam int unsigned B_ACC      = 33;
  localparam int unsigned B_CEN_P    = 32;
  localparam int unsigned B_WEN_P    = 31;
  localparam int unsigned B_AP_HI    = 30;
  localparam int unsigned B_AP_LO    = 20;
  localparam int unsigned B_CEN_X    = 19;
  localparam int unsigned B_WEN_X    = 18;
  localparam int unsigned B_AX_HI    = 17;
  localparam int unsigned B_AX_LO    = 7;
  localparam int unsigned B_OFIFO_RD = 6;
  localparam int unsigned B_IFIFO_WR = 5;
  localparam int unsigned B_IFIFO_RD = 4;
  localparam int unsigned B_L0_RD    = 3;
  localparam int unsigned B_L0_WR    = 2;
  localparam int unsigned B_EXEC     = 1;
  localparam int unsigned B_LOAD     = 0;

  // Both SRAMs deselected and write-disabled, every strobe low
  localparam logic [INST_W-1:0] IDLE_WORD =
    (INST_W'(1) << B_CEN_P) | (INST_W'(1) << B_WEN_P) |
    (INST_W'(1) << B_CEN_X) | (INST_W'(1) << B_WEN_X);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CRST,
    S_WL0,
    S_WLD,
    S_GAP,
    S_XL0,
    S_EXE,
    S_DRN,
    S_DONE
  } state_t;

endpackage

// File: rtl/core_inst_seq_pack.sv
// Combinational packer: individual control fields -> 34-bit core instruction.
module core_inst_pack
  import core_inst_seq_pkg::*;
(
  input  logic              acc,
  input  logic              cen_pmem,
  input  logic              wen_pmem,
  input  logic [ADDR_W-1:0] a_pmem,
  input  logic              cen_xmem,
  input  logic              wen_xmem,
  input  logic [ADDR_W-1:0] a_xmem,
  input  logic              ofifo_rd,
  input  logic              ififo_wr,
  input  logic              ififo_rd,
  input  logic              l0_rd,
  input  logic              l0_wr,
  input  logic              execute,
  input  logic              load,
  output logic [INST_W-1:0] inst
);

  // Place each field at its fixed bit position
  always_comb begin
    inst                    = '0;
    inst[B_ACC]             = acc;
    inst[B_CEN_P]           = cen_pmem;
    inst[B_WEN_P]           = wen_pmem;
    inst[B_AP_HI:B_AP_LO]   = a_pmem;
    inst[B_CEN_X]           = cen_xmem;
    inst[B_WEN_X]           = wen_xmem;
    inst[B_AX_HI:B_AX_LO]   = a_xmem;
    inst[B_OFIFO_RD]        = ofifo_rd;
    inst[B_IFIFO_WR]        = ififo_wr;
    inst[B_IFIFO_RD]        = ififo_rd;
    inst[B_L0_RD]           = l0_rd;
    inst[B_L0_WR]           = l0_wr;
    inst[B_EXEC]            = execute;
    inst[B_LOAD]            = load;
  end

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer for the core: walks every kernel position through
// kernel load, PE load, activation load, execute and OFIFO->pmem drain,
// emitting one registered instruction word per cycle.
module core_inst_seq
  import core_inst_seq_pkg::*;
#(
  parameter int unsigned       COL      = 8,
  parameter int unsigned       ROW      = 8,
  parameter int unsigned       LEN_KIJ  = 9,
  parameter int unsigned       LEN_NIJ  = 36,
  parameter int unsigned       LEN_ONIJ = 16,
  parameter logic [ADDR_W-1:0] XBASE    = 11'h000,
  parameter logic [ADDR_W-1:0] KBASE    = 11'h400,
  parameter int unsigned       RST_CYC  = 10,
  parameter int unsigned       GAP_CYC  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              core_rst,
  output logic [KIJ_W-1:0]  kij,
  output logic              busy,
  output logic              done
);

  // Sized to the longest phase (execute); all other phases fit below it
  localparam int unsigned CNT_W = $clog2(ROW * LEN_NIJ + 1);

  localparam logic [CNT_W-1:0] RST_N    = CNT_W'(RST_CYC);
  localparam logic [CNT_W-1:0] WL0_N    = CNT_W'(COL);
  localparam logic [CNT_W-1:0] WLD_N    = CNT_W'(COL * LEN_KIJ);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] XL0_N    = CNT_W'(LEN_NIJ);
  localparam logic [CNT_W-1:0] EXE_N    = CNT_W'(ROW * LEN_NIJ);
  localparam logic [CNT_W-1:0] DRN_N    = CNT_W'(LEN_ONIJ);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [KIJ_W-1:0] KIJ_LAST = KIJ_W'(LEN_KIJ - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   widx_q, widx_d;
  logic               pend_q, pend_d;
  logic [KIJ_W-1:0]   kij_q, kij_d;

  logic               cen_p, wen_p, cen_x, wen_x;
  logic [ADDR_W-1:0]  a_p, a_x;
  logic               ofifo_rd, l0_rd, l0_wr, execute, load;
  logic               core_rst_c, busy_c, done_c;
  logic [INST_W-1:0]  inst_c;

  assign kij = kij_q;

  // Next-state, counter updates and instruction fields for the coming cycle
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q + CNT_ONE;
    dcnt_d     = dcnt_q;
    widx_d     = widx_q;
    pend_d     = 1'b0;
    kij_d      = kij_q;
    cen_p      = 1'b1;
    wen_p      = 1'b1;
    a_p        = '0;
    cen_x      = 1'b1;
    wen_x      = 1'b1;
    a_x        = '0;
    ofifo_rd   = 1'b0;
    l0_rd      = 1'b0;
    l0_wr      = 1'b0;
    execute    = 1'b0;
    load       = 1'b0;
    core_rst_c = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_c  = 1'b0;
        phase_d = '0;
        if (start) begin
          state_d = S_CRST;
          kij_d   = '0;
          busy_c  = 1'b1;
        end
      end
      S_CRST: begin
        core_rst_c = (phase_q < RST_N);
        if (phase_q == RST_N) begin
          state_d = S_WL0;
          phase_d = '0;
        end
      end
      S_WL0: begin
        // l0_wr trails the xmem read by one cycle to cover SRAM read latency
        if (phase_q < WL0_N) begin
          cen_x = 1'b0;
          a_x   = KBASE + ADDR_W'(kij_q) * ADDR_W'(COL) + ADDR_W'(phase_q);
        end
        l0_wr = (phase_q != '0);
        if (phase_q == WL0_N) begin
          state_d = S_WLD;
          phase_d = '0;
        end
      end
      S_WLD: begin
        if (phase_q < WLD_N) begin
          load  = 1'b1;
          l0_rd = 1'b1;
        end else begin
          state_d = S_GAP;
          phase_d = '0;
        end
      end
      S_GAP: begin
        if (phase_q == GAP_LAST) begin
          state_d = S_XL0;
          phase_d = '0;
        end
      end
      S_XL0: begin
        if (phase_q < XL0_N) begin
          cen_x = 1'b0;
          a_x   = XBASE + ADDR_W'(phase_q);
        end
        l0_wr = (phase_q != '0);
        if (phase_q == XL0_N) begin
          state_d = S_EXE;
          phase_d = '0;
        end
      end
      S_EXE: begin
        if (phase_q < EXE_N) begin
          execute = 1'b1;
          l0_rd   = 1'b1;
        end else begin
          state_d = S_DRN;
          phase_d = '0;
          dcnt_d  = '0;
        end
      end
      S_DRN: begin
        phase_d = '0;
        // A read accepted last cycle is written to pmem this cycle; reads and
        // writes overlap when ofifo_valid stays high
        if (pend_q) begin
          cen_p = 1'b0;
          wen_p = 1'b0;
          a_p   = ADDR_W'(kij_q) * ADDR_W'(LEN_ONIJ) + ADDR_W'(widx_q);
        end
        if (ofifo_valid && (dcnt_q < DRN_N)) begin
          ofifo_rd = 1'b1;
          pend_d   = 1'b1;
          widx_d   = dcnt_q;
          dcnt_d   = dcnt_q + CNT_ONE;
        end
        if (pend_q && (dcnt_q == DRN_N)) begin
          if (kij_q == KIJ_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CRST;
            kij_d   = kij_q + KIJ_W'(1);
          end
        end
      end
      S_DONE: begin
        busy_c  = 1'b0;
        done_c  = 1'b1;
        phase_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_c  = 1'b0;
      end
    endcase
  end

  core_inst_pack u_pack (
    .acc      (1'b0),
    .cen_pmem (cen_p),
    .wen_pmem (wen_p),
    .a_pmem   (a_p),
    .cen_xmem (cen_x),
    .wen_xmem (wen_x),
    .a_xmem   (a_x),
    .ofifo_rd (ofifo_rd),
    .ififo_wr (1'b0),
    .ififo_rd (1'b0),
    .l0_rd    (l0_rd),
    .l0_wr    (l0_wr),
    .execute  (execute),
    .load     (load),
    .inst     (inst_c)
  );

  // State, counters and all outputs registered; reset aborts any run
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      dcnt_q   <= '0;
      widx_q   <= '0;
      pend_q   <= 1'b0;
      kij_q    <= '0;
      inst     <= IDLE_WORD;
      core_rst <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dcnt_q   <= dcnt_d;
      widx_q   <= widx_d;
      pend_q   <= pend_d;
      kij_q    <= kij_d;
      inst     <= inst_c;
      core_rst <= core_rst_c;
      busy     <= busy_c;
      done     <= done_c;
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq: stimulus queues expected xmem/pmem
// addresses and pulse lengths, a negedge monitor pops and compares them.
module tb_core_inst_seq;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic [33:0] inst;
  logic        core_rst;
  logic [3:0]  kij;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  int q_xa[$], q_xk[$], q_pa[$];
  int q_rst[$], q_load[$], q_exe[$], q_l0wr[$];

  int   rst_run = 0, load_run = 0, exe_run = 0, l0wr_run = 0;
  logic prev_xrd = 1'b0, prev_ofrd = 1'b0, prev_valid = 1'b0, prev_done = 1'b0;
  int   n_pw = 0, n_done = 0;
  int   ea, ek;

  core_inst_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .core_rst    (core_rst),
    .kij         (kij),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_kij(input int k, input bit with_drain);
    q_rst.push_back(10);
    for (int t = 0; t < 8; t++) begin
      q_xa.push_back(32'h400 + k * 8 + t);
      q_xk.push_back(k);
    end
    q_l0wr.push_back(8);
    q_load.push_back(72);
    for (int t = 0; t < 36; t++) begin
      q_xa.push_back(t);
      q_xk.push_back(k);
    end
    q_l0wr.push_back(36);
    if (with_drain) begin
      q_exe.push_back(288);
      for (int i = 0; i < 16; i++) q_pa.push_back(k * 16 + i);
    end
  endtask

  // OFIFO model: always valid on even kij, alternating on odd kij
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (kij[0]) ofifo_valid = ~ofifo_valid;
      else        ofifo_valid = 1'b1;
    end
  end

  // Monitor: pops expectations as the DUT presents reads, writes and pulses
  always @(negedge clk) begin
    if (reset) begin
      rst_run = 0; load_run = 0; exe_run = 0; l0wr_run = 0;
      prev_xrd = 1'b0; prev_ofrd = 1'b0; prev_valid = 1'b0; prev_done = 1'b0;
    end else begin
      if (inst[19] == 1'b0) begin
        if (q_xa.size() == 0) chk("xmem_unexpected", int'(inst[17:7]), -1);
        else begin
          ea = q_xa.pop_front();
          ek = q_xk.pop_front();
          chk("xmem_addr", int'(inst[17:7]), ea);
          chk("xmem_wen", int'(inst[18]), 1);
          chk("kij_at_xread", int'(kij), ek);
        end
      end
      if (inst[32] == 1'b0) begin
        n_pw++;
        if (q_pa.size() == 0) chk("pmem_unexpected", int'(inst[30:20]), -1);
        else begin
          chk("pmem_addr", int'(inst[30:20]), q_pa.pop_front());
          chk("pmem_wen", int'(inst[31]), 0);
        end
      end
      if (inst[2] || prev_xrd) chk("l0_wr_lag", int'(inst[2]), int'(prev_xrd));
      if (!inst[32] || prev_ofrd) chk("pmem_after_read", int'(!inst[32]), int'(prev_ofrd));
      if (inst[6]) chk("ofifo_rd_while_invalid", int'(prev_valid), 1);
      if (inst[3] || inst[0] || inst[1]) chk("l0_rd", int'(inst[3]), int'(inst[0] | inst[1]));
      if (busy) chk("acc_ififo_zero", int'({inst[33], inst[5], inst[4]}), 0);
      if (core_rst) chk("busy_in_core_rst", int'(busy), 1);
      if (done) begin
        n_done++;
        chk("done_busy_low", int'(busy), 0);
        chk("done_writes_left", q_pa.size(), 0);
        chk("done_one_cycle", int'(prev_done), 0);
      end

      if (core_rst) rst_run++;
      else if (rst_run > 0) begin
        if (q_rst.size() == 0) chk("core_rst_unexpected", rst_run, 0);
        else chk("core_rst_len", rst_run, q_rst.pop_front());
        rst_run = 0;
      end
      if (inst[0]) load_run++;
      else if (load_run > 0) begin
        if (q_load.size() == 0) chk("load_unexpected", load_run, 0);
        else chk("load_len", load_run, q_load.pop_front());
        load_run = 0;
      end
      if (inst[1]) exe_run++;
      else if (exe_run > 0) begin
        if (q_exe.size() == 0) chk("execute_unexpected", exe_run, 0);
        else chk("execute_len", exe_run, q_exe.pop_front());
        exe_run = 0;
      end
      if (inst[2]) l0wr_run++;
      else if (l0wr_run > 0) begin
        if (q_l0wr.size() == 0) chk("l0_wr_unexpected", l0wr_run, 0);
        else chk("l0_wr_len", l0wr_run, q_l0wr.pop_front());
        l0wr_run = 0;
      end

      prev_xrd   = !inst[19];
      prev_ofrd  = inst[6];
      prev_valid = ofifo_valid;
      prev_done  = done;
    end
  end

  initial begin
    bit seen;

    // Reset state, then idle with no start
    repeat (5) @(posedge clk);
    #1;
    chk_w("reset_inst", inst, IDLE_W);
    chk("reset_busy", int'(busy), 0);
    chk("reset_kij", int'(kij), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk_w("idle_inst", inst, IDLE_W);
      chk("idle_busy", int'(busy), 0);
      chk("idle_core_rst", int'(core_rst), 0);
      chk("idle_done", int'(done), 0);
    end

    // Full run over all kernel positions; a stray start mid-run is ignored
    for (int k = 0; k < 9; k++) push_kij(k, 1'b1);
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    repeat (300) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 20000 && n_done == 0; i++) @(negedge clk);
    if (n_done == 0) chk("done_timeout", 0, 1);
    repeat (5) @(negedge clk);
    chk("pmem_write_total", n_pw, 144);
    chk("done_pulse_count", n_done, 1);
    chk("busy_after_done", int'(busy), 0);
    chk_w("inst_after_done", inst, IDLE_W);

    // Second run aborted by reset during execute
    push_kij(0, 1'b0);
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (inst[1] && dut.kij == 4'd0) seen = 1'b1;
    end
    if (!seen) chk("execute_timeout", 0, 1);
    repeat (20) @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_w("abort_inst", inst, IDLE_W);
    chk("abort_busy", int'(busy), 0);
    chk("abort_core_rst", int'(core_rst), 0);
    chk("abort_kij", int'(kij), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk_w("post_abort_inst", inst, IDLE_W);
    chk("left_xmem", q_xa.size(), 0);
    chk("left_pmem", q_pa.size(), 0);
    chk("left_core_rst", q_rst.size(), 0);
    chk("left_load", q_load.size(), 0);
    chk("left_execute", q_exe.size(), 0);
    chk("left_l0_wr", q_l0wr.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
